// File: rtl/counter_share_arbiter.sv
// Round-robin shared counter: N_REQ requesters issue READ/INC/ADD/LOAD ops.
// Define COUNTER_SHARE_SAT_EN for saturating arithmetic and a sat_hit output.
module counter_share_arbiter #(
  parameter  int N_REQ = 4,
  parameter  int WIDTH = 8,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [2*N_REQ-1:0] op,
  input  logic [WIDTH*N_REQ-1:0] din,
  input  logic               auto_inc,
  output logic [N_REQ-1:0]   ack,
  output logic               rsp_valid,
  output logic [ID_W-1:0]    rsp_id,
  output logic [WIDTH-1:0]   rsp_data,
  output logic [WIDTH-1:0]   count
`ifdef COUNTER_SHARE_SAT_EN
  ,
  output logic               sat_hit
`endif
);

  typedef enum logic [1:0] {
    OP_READ = 2'b00,
    OP_INC  = 2'b01,
    OP_ADD  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  logic [ID_W-1:0]  ptr;
  logic [N_REQ-1:0] mask;
  logic [N_REQ-1:0] elig;
  logic [ID_W-1:0]  win;
  logic [ID_W-1:0]  ptr_nxt;
  logic             found;
  logic [N_REQ-1:0] oh;
  op_e              op_w;
  logic [WIDTH-1:0] din_w;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] load_val;
  logic             use_add;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] count_nxt;

  function automatic logic [ID_W-1:0] rot(
    input logic [ID_W-1:0] p,
    input int              k
  );
    int s;
    s = int'(p) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return ID_W'(s);
  endfunction

  assign elig = req & ~mask;

  // Scan from the far end so the lowest offset from ptr wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (elig[rot(ptr, k)]) begin
        win   = rot(ptr, k);
        found = 1'b1;
      end
    end
  end

  assign ptr_nxt = (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
  assign oh      = N_REQ'(1) << win;
  assign op_w    = op_e'(op[2*int'(win) +: 2]);
  assign din_w   = din[WIDTH*int'(win) +: WIDTH];

  always_comb begin
    use_add  = 1'b0;
    addend   = WIDTH'(1);
    load_val = count;
    if (found) begin
      unique case (op_w)
        OP_READ: load_val = count;
        OP_INC:  use_add  = 1'b1;
        OP_ADD: begin
          use_add = 1'b1;
          addend  = din_w;
        end
        OP_LOAD: load_val = din_w;
      endcase
    end else if (auto_inc) begin
      use_add = 1'b1;
    end
  end

`ifdef COUNTER_SHARE_SAT_EN
  logic [WIDTH:0] sum_ext;
  logic           clip;
  assign sum_ext = {1'b0, count} + {1'b0, addend};
  assign clip    = use_add & sum_ext[WIDTH];
  assign sum     = sum_ext[WIDTH] ? {WIDTH{1'b1}} : sum_ext[WIDTH-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) sat_hit <= 1'b0;
    else       sat_hit <= clip;
  end
`else
  assign sum = count + addend;
`endif

  assign count_nxt = use_add ? sum : load_val;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count     <= '0;
      ptr       <= '0;
      mask      <= '0;
      ack       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      count <= count_nxt;
      if (found) begin
        ptr       <= ptr_nxt;
        mask      <= oh;
        ack       <= oh;
        rsp_valid <= 1'b1;
        rsp_id    <= win;
        rsp_data  <= count_nxt;
      end else begin
        mask      <= '0;
        ack       <= '0;
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
